traffic_intersection_ctrl: RTL and testbench

//  Sequences two opposing traffic-light heads (direction A, direction B) and one

---
 rtl/traffic_pkg.sv | 52 +++++
 rtl/phase_timer.sv | 34 +++
 rtl/traffic_intersection_ctrl.sv | 137 +++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the intersection controller: the phase state type
//   (its encoding is visible on the phase output), default timing values,
//   the per-head lamp encoding and lamp decode helpers.
// ---------------------------------------------------------------------------
package traffic_pkg;

  // The encoding is observable on the phase port, so the values are fixed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_GRN  = 3'd1,
    A_YEL  = 3'd2,
    RED_AB = 3'd3,
    B_GRN  = 3'd4,
    B_YEL  = 3'd5,
    RED_BA = 3'd6,
    WALK   = 3'd7
  } state_e;

  // Default dwell times, in clock cycles.
  localparam int GREEN_MIN_DEF  = 4;
  localparam int GREEN_MAX_DEF  = 10;
  localparam int YELLOW_CYC_DEF = 2;
  localparam int ALLRED_CYC_DEF = 1;
  localparam int WALK_CYC_DEF   = 3;
  localparam int CNT_W_DEF      = 8;

  // Per-head lamp encoding, ordered {red, yellow, green}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Head A is only ever non-red in its own green/yellow phases.
  function automatic logic [2:0] lamp_a(input state_e s);
    case (s)
      A_GRN:   return LAMP_G;
      A_YEL:   return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

  // Head B mirrors head A.
  function automatic logic [2:0] lamp_b(input state_e s);
    case (s)
      B_GRN:   return LAMP_G;
      B_YEL:   return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//   Dwell counter for the current phase. Comparisons against the phase
//   limits are made by the controller; this block only counts.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous active-high reset, clears the count
//     clr    in   synchronous clear (priority over en)
//     en     in   count enable, +1 per enabled cycle
//     cnt    out  current count, CNT_W bits
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_intersection_ctrl
//   Phase sequencer for two opposing traffic heads (A, B) and a pedestrian
//   crossing. Owns phase order, dwell timing and demand arbitration; the
//   lamp outputs are a Moore decode of the state register.
//   Ports:
//     clk            in   clock, rising edge
//     reset          in   asynchronous active-high reset, clears all state
//     start          in   1 = run, 0 = freeze state and timer
//     car_a, car_b   in   vehicle demand on direction A / B (level)
//     ped_req        in   pedestrian button (pulse or level)
//     ra, ya, ga     out  head A red/yellow/green, one-hot
//     rb, yb, gb     out  head B red/yellow/green, one-hot
//     walk           out  pedestrian walk lamp
//     phase          out  current state encoding
// ---------------------------------------------------------------------------
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = GREEN_MIN_DEF,
  parameter int GREEN_MAX  = GREEN_MAX_DEF,
  parameter int YELLOW_CYC = YELLOW_CYC_DEF,
  parameter int ALLRED_CYC = ALLRED_CYC_DEF,
  parameter int WALK_CYC   = WALK_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       car_a,
  input  logic       car_b,
  input  logic       ped_req,
  output logic       ra,
  output logic       ya,
  output logic       ga,
  output logic       rb,
  output logic       yb,
  output logic       gb,
  output logic       walk,
  output logic [2:0] phase
);

  // Terminal counts: a phase of N cycles ends on the cycle where t == N-1.
  localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK_CYC - 1);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] t;
  logic             ped_pend;
  logic             came_from_a;
  logic             moving;
  logic             enter_walk;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_nxt is defaulted to the current state before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (start) begin
      case (state)
        IDLE:   state_nxt = A_GRN;
        A_GRN:  if ((t == T_GMAX) || ((t >= T_GMIN) && (car_b || ped_pend)))
                  state_nxt = A_YEL;
        A_YEL:  if (t == T_YEL) state_nxt = RED_AB;
        RED_AB: if (t == T_AR) state_nxt = ped_pend ? WALK : B_GRN;
        B_GRN:  if ((t == T_GMAX) || ((t >= T_GMIN) && (car_a || ped_pend)))
                  state_nxt = B_YEL;
        B_YEL:  if (t == T_YEL) state_nxt = RED_BA;
        RED_BA: if (t == T_AR) state_nxt = ped_pend ? WALK : A_GRN;
        WALK:   if (t == T_WALK) state_nxt = came_from_a ? B_GRN : A_GRN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // No state loops back to itself, so any change of state is a transition.
  assign moving     = (state_nxt != state);
  assign enter_walk = moving && (state_nxt == WALK);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A request coinciding with WALK entry is served by that walk, so the
  // clear takes priority; requests during WALK re-arm for the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pend <= 1'b0;
    end else if (enter_walk) begin
      ped_pend <= 1'b0;
    end else if (ped_req) begin
      ped_pend <= 1'b1;
    end
  end

  // Remembers which all-red fed the walk so the following green goes to the
  // direction that was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      came_from_a <= 1'b0;
    end else if (enter_walk) begin
      came_from_a <= (state == RED_AB);
    end
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (moving),
    .en    (start),
    .cnt   (t)
  );

  // -------------------------------------------------------------------------
  // Moore output decode
  // -------------------------------------------------------------------------
  assign {ra, ya, ga} = lamp_a(state);
  assign {rb, yb, gb} = lamp_b(state);
  assign walk         = (state == WALK);
  assign phase        = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_intersection_ctrl
//   Scoreboard bench: the driver steps a phase/elapsed-time reference model
//   on every clock and queues the expected outputs; a monitor on the falling
//   edge pops and compares them, and checks the lamp invariants.
// ---------------------------------------------------------------------------
module tb_traffic_intersection_ctrl;

  localparam int GMIN = 4, GMAX = 10, YEL = 2, AR = 1, WLK = 3;
  localparam int P_IDLE = 0, P_AG = 1, P_AY = 2, P_RAB = 3,
                 P_BG = 4, P_BY = 5, P_RBA = 6, P_WALK = 7;

  logic clk = 1'b0;
  logic reset, start, car_a, car_b, ped_req;
  logic ra, ya, ga, rb, yb, gb, walk;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];

  // Reference model: phase, cycles already spent in it, pending walk
  // request, and which green follows the walk.
  int   m_ph, m_el, m_after;
  logic m_pend;

  always #5 clk = ~clk;

  traffic_intersection_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .car_a   (car_a),
    .car_b   (car_b),
    .ped_req (ped_req),
    .ra      (ra),
    .ya      (ya),
    .ga      (ga),
    .rb      (rb),
    .yb      (yb),
    .gb      (gb),
    .walk    (walk),
    .phase   (phase)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // {ra,ya,ga, rb,yb,gb, walk} for each phase.
  function automatic logic [6:0] lamps(input int ph);
    case (ph)
      P_AG:    return 7'b001_100_0;
      P_AY:    return 7'b010_100_0;
      P_BG:    return 7'b100_001_0;
      P_BY:    return 7'b100_010_0;
      P_WALK:  return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  // Does the phase end after this cycle, given how many cycles it has
  // lasted including this one?
  function automatic bit phase_done(input int ph, input int lasted, input bit demand);
    case (ph)
      P_IDLE:       return 1'b1;
      P_AG, P_BG:   return (lasted >= GMAX) || ((lasted >= GMIN) && demand);
      P_AY, P_BY:   return lasted == YEL;
      P_RAB, P_RBA: return lasted == AR;
      default:      return lasted == WLK;
    endcase
  endfunction

  function automatic int successor(input int ph, input bit pend, input int after);
    case (ph)
      P_IDLE:  return P_AG;
      P_AG:    return P_AY;
      P_AY:    return P_RAB;
      P_RAB:   return pend ? P_WALK : P_BG;
      P_BG:    return P_BY;
      P_BY:    return P_RBA;
      P_RBA:   return pend ? P_WALK : P_AG;
      default: return after;
    endcase
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_el = 0; m_pend = 1'b0; m_after = P_AG;
  endtask

  task automatic m_step(input logic s, input logic ca, input logic cb, input logic pd);
    bit demand, moved;
    int nxt;
    moved = 1'b0;
    if (s) begin
      demand = (m_ph == P_AG) ? (cb || m_pend) : (ca || m_pend);
      if (phase_done(m_ph, m_el + 1, demand)) begin
        nxt = successor(m_ph, m_pend, m_after);
        if (nxt == P_WALK) m_after = (m_ph == P_RAB) ? P_BG : P_AG;
        m_ph  = nxt;
        m_el  = 0;
        moved = 1'b1;
      end else begin
        m_el++;
      end
    end
    if (moved && m_ph == P_WALK) m_pend = 1'b0;
    else if (pd)                 m_pend = 1'b1;
  endtask

  function automatic logic [9:0] expect_now();
    logic [2:0] p;
    p = 3'(m_ph);
    return {p, lamps(m_ph)};
  endfunction

  // One clock of stimulus; returns at #1 after the edge.
  task automatic cycle(input logic r, input logic s, input logic ca, input logic cb, input logic pd);
    reset = r; start = s; car_a = ca; car_b = cb; ped_req = pd;
    if (r) begin
      m_reset();
      exp_q.delete();
      exp_q.push_back(expect_now());
    end
    @(posedge clk);
    if (r) m_reset();
    else   m_step(s, ca, cb, pd);
    exp_q.push_back(expect_now());
    #1;
  endtask

  // Monitor: compare queued expectations and invariants on the falling edge.
  always @(negedge clk) begin
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {phase, ra, ya, ga, rb, yb, gb, walk}, e);
      check("invariants",
            {$onehot({ra, ya, ga}), $onehot({rb, yb, gb}), !(ga && gb),
             !(walk && (ga || gb))}, 4'b1111);
    end
  end

  localparam int S_GA = 0, S_YA = 1, S_GB = 2, S_YB = 3, S_WALK = 4, S_RAB = 5, S_RBA = 6;

  function automatic bit sig(input int sel);
    case (sel)
      S_GA:    return ga;
      S_YA:    return ya;
      S_GB:    return gb;
      S_YB:    return yb;
      S_WALK:  return walk;
      S_RAB:   return phase == 3'd3;
      default: return phase == 3'd6;
    endcase
  endfunction

  logic drv_ca = 1'b0, drv_cb = 1'b0;

  // Count consecutive observed cycles of a condition, starting with the
  // current one; bounded so a stuck DUT still reaches the summary.
  task automatic run_len(input int sel, input string name, input int exp_len);
    int len;
    len = 0;
    while (sig(sel) && len < 40) begin
      len++;
      cycle(1'b0, 1'b1, drv_ca, drv_cb, 1'b0);
    end
    check(name, len, exp_len);
  endtask

  initial begin
    m_reset();
    reset = 1'b1; start = 1'b1; car_a = 1'b0; car_b = 1'b0; ped_req = 1'b0;

    // Reset holds all-red idle even with start high.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_phase", phase, 0);
    check("reset_lamps", {ra, ya, ga, rb, yb, gb, walk}, 7'b100_100_0);

    // Release: A green on the next edge.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("first_green", {phase, ga}, {3'd1, 1'b1});

    // Fixed-time fallback, both directions.
    run_len(S_GA,  "a_green_nodemand", 10);
    run_len(S_YA,  "a_yellow", 2);
    run_len(S_RAB, "red_ab", 1);
    check("b_green_after_red", gb, 1);
    run_len(S_GB,  "b_green_nodemand", 10);
    run_len(S_YB,  "b_yellow", 2);
    run_len(S_RBA, "red_ba", 1);
    check("a_green_again", ga, 1);

    // Opposing demand from the first A green cycle: minimum green.
    drv_cb = 1'b1;
    run_len(S_GA, "a_green_car_b", 4);
    check("a_yellow_after_min", ya, 1);
    drv_cb = 1'b0;
    run_len(S_YA,  "a_yellow_2", 2);
    run_len(S_RAB, "red_ab_2", 1);
    run_len(S_GB,  "b_green_2", 10);
    run_len(S_YB,  "b_yellow_2", 2);
    run_len(S_RBA, "red_ba_2", 1);

    // Pedestrian pulse at A green t=1: green ends at t=3, then walk.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_len(S_GA,  "a_green_ped_rest", 2);
    run_len(S_YA,  "a_yellow_ped", 2);
    run_len(S_RAB, "red_ab_ped", 1);
    check("walk_entry", {phase, ra, rb, walk}, {3'd7, 3'b111});
    run_len(S_WALK, "walk_len", 3);
    check("b_green_after_walk", {phase, gb}, {3'd4, 1'b1});
    run_len(S_GB,  "b_green_ped_cleared", 10);
    run_len(S_YB,  "b_yellow_3", 2);
    run_len(S_RBA, "red_ba_3", 1);
    run_len(S_GA,  "a_green_3", 10);

    // Freeze mid A yellow, then resume with the remaining count.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("freeze_hold", {phase, ya}, {3'd2, 1'b1});
    end
    run_len(S_YA, "a_yellow_resumed", 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("b_green_before_reset", gb, 1);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("async_reset_lamps", {phase, ra, ya, ga, rb, yb, gb, walk}, {3'd0, 7'b100_100_0});
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0);
    end

    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
